arith_sched: RTL and testbench

- Two-requester scheduler and sequencer for the shared combinational sign-magnitude arithmetic unit (add/sub/mul/div, 128-bit magnitude plus sign bit).
- Arbitrates between requesters round-robin and registers the winner's operands onto the unit's inputs.
- Holds those inputs stable for a programmed settle time, then captures the result and returns it with a requester ID on a valid/ready response channel.
- Exactly one operation is in flight at a time.

---
 rtl/arith_sched.sv | 151 +++++++++++++++
 tb/tb_arith_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_sched.sv
// arith_sched: two-requester round-robin scheduler and sequencer for the shared
// combinational sign-magnitude arithmetic unit. One operation in flight at a time.
// Optional macro ARITH_SCHED_DZ_FLAG_EN adds resp_dz and a fast path for div by zero.
module arith_sched #(
   parameter int DW         = 128,
   parameter int ADDSUB_LAT = 1,
   parameter int MULDIV_LAT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [1:0]    req0_op,
   input  logic [DW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   input  logic          req0_sa,
   input  logic          req0_sb,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [1:0]    req1_op,
   input  logic [DW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   input  logic          req1_sa,
   input  logic          req1_sb,
   output logic [DW-1:0] dp_num_a,
   output logic [DW-1:0] dp_num_b,
   output logic          dp_sign_a,
   output logic          dp_sign_b,
   output logic [1:0]    dp_op,
   input  logic [DW-1:0] dp_res,
   input  logic          dp_sign,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic          resp_id,
   output logic [DW-1:0] resp_res,
   output logic          resp_sign,
`ifdef ARITH_SCHED_DZ_FLAG_EN
   output logic          resp_dz,
`endif
   output logic          busy
);

   // Settle times clamped to at least one cycle; counter is 8 bits wide.
   localparam int         ADD_L = (ADDSUB_LAT < 1) ? 1 : ADDSUB_LAT;
   localparam int         MUL_L = (MULDIV_LAT < 1) ? 1 : MULDIV_LAT;
   localparam logic [7:0] ADD_C = 8'(ADD_L);
   localparam logic [7:0] MUL_C = 8'(MUL_L);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state, state_nxt;
   logic [7:0]      cnt;
   logic            last_grant;
   logic            id_q;
   logic            grant0, grant1;
   logic            accept;
   logic [1:0]      op_sel;
   logic [DW-1:0]   a_sel, b_sel;
   logic            sa_sel, sb_sel;
   logic [7:0]      cnt_load;

   // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_grant);
      grant1 = req1_valid & (~req0_valid | ~last_grant);
   end

   assign accept = (state == S_IDLE) & (req0_valid | req1_valid);

   // Winner's payload and the settle time it needs.
   always_comb begin
      op_sel   = grant1 ? req1_op : req0_op;
      a_sel    = grant1 ? req1_a  : req0_a;
      b_sel    = grant1 ? req1_b  : req0_b;
      sa_sel   = grant1 ? req1_sa : req0_sa;
      sb_sel   = grant1 ? req1_sb : req0_sb;
      cnt_load = op_sel[1] ? MUL_C : ADD_C;
`ifdef ARITH_SCHED_DZ_FLAG_EN
      // Divide by zero has a fixed answer, so skip the long settle.
      if (op_sel == 2'b11 && b_sel == '0) cnt_load = 8'd1;
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      resp_valid = 1'b0;
      busy       = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            req0_ready = grant0;
            req1_ready = grant1;
            if (accept) state_nxt = S_WAIT;
         end
         S_WAIT: if (cnt == 8'd1) state_nxt = S_RESP;
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand launch, settle countdown and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_num_a   <= '0;
         dp_num_b   <= '0;
         dp_sign_a  <= 1'b0;
         dp_sign_b  <= 1'b0;
         dp_op      <= 2'b00;
         cnt        <= 8'd0;
         last_grant <= 1'b1;
         id_q       <= 1'b0;
         resp_id    <= 1'b0;
         resp_res   <= '0;
         resp_sign  <= 1'b0;
`ifdef ARITH_SCHED_DZ_FLAG_EN
         resp_dz    <= 1'b0;
`endif
      end else if (accept) begin
         dp_num_a   <= a_sel;
         dp_num_b   <= b_sel;
         dp_sign_a  <= sa_sel;
         dp_sign_b  <= sb_sel;
         dp_op      <= op_sel;
         cnt        <= cnt_load;
         last_grant <= grant1;
         id_q       <= grant1;
      end else if (state == S_WAIT) begin
         cnt <= cnt - 8'd1;
         if (cnt == 8'd1) begin
            resp_res  <= dp_res;
            resp_sign <= dp_sign;
            resp_id   <= id_q;
`ifdef ARITH_SCHED_DZ_FLAG_EN
            resp_dz   <= (dp_op == 2'b11) && (dp_num_b == '0);
`endif
         end
      end
   end

endmodule

// File: tb/tb_arith_sched.sv
// tb_arith_sched: directed and randomized checks of arith_sched against a
// transaction-level model; the bench also plays the arithmetic unit.
module tb_arith_sched;
   localparam int DW = 128;
   localparam int ADD_L = 1;
   localparam int MUL_L = 4;
`ifdef ARITH_SCHED_DZ_FLAG_EN
   localparam int DZ_L = 1;
`else
   localparam int DZ_L = MUL_L;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic          req0_ready, req1_ready;
   logic [1:0]    req0_op = '0, req1_op = '0;
   logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic          req0_sa = 1'b0, req0_sb = 1'b0, req1_sa = 1'b0, req1_sb = 1'b0;
   logic [DW-1:0] dp_num_a, dp_num_b, dp_res;
   logic          dp_sign_a, dp_sign_b, dp_sign;
   logic [1:0]    dp_op;
   logic          resp_valid, resp_ready = 1'b1, resp_id, resp_sign, busy;
   logic [DW-1:0] resp_res;
`ifdef ARITH_SCHED_DZ_FLAG_EN
   logic          resp_dz;
`endif

   int checks = 0;
   int errors = 0;

   arith_sched #(.DW(DW), .ADDSUB_LAT(ADD_L), .MULDIV_LAT(MUL_L)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b), .req0_sa(req0_sa), .req0_sb(req0_sb),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b), .req1_sa(req1_sa), .req1_sb(req1_sb),
      .dp_num_a(dp_num_a), .dp_num_b(dp_num_b), .dp_sign_a(dp_sign_a),
      .dp_sign_b(dp_sign_b), .dp_op(dp_op), .dp_res(dp_res), .dp_sign(dp_sign),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_res(resp_res), .resp_sign(resp_sign),
`ifdef ARITH_SCHED_DZ_FLAG_EN
      .resp_dz(resp_dz),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Sign-magnitude arithmetic unit: returns {sign, magnitude}.
   function automatic logic [DW:0] unit_f(input logic [1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic sa, input logic sb);
      logic [DW-1:0] m;
      logic s, sbe;
      m = '0; s = 1'b0; sbe = sb ^ op[0];
      case (op)
         2'b00, 2'b01: begin
            if (sa == sbe)   begin m = a + b; s = sa;  end
            else if (a >= b) begin m = a - b; s = sa;  end
            else             begin m = b - a; s = sbe; end
         end
         2'b10: begin m = a * b; s = sa ^ sb; end
         default: begin
            if (b == '0) begin m = '1;    s = sa; end
            else         begin m = a / b; s = sa ^ sb; end
         end
      endcase
      return {s, m};
   endfunction

   always_comb {dp_sign, dp_res} = unit_f(dp_op, dp_num_a, dp_num_b, dp_sign_a, dp_sign_b);

   task automatic chk(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Transaction model: idle / settling for a number of edges / holding a response.
   int            m_mode;   // 0 idle, 1 settling, 2 response held
   int            m_left;
   logic          m_last, m_id, m_rsign, m_dz;
   logic [DW-1:0] m_res, m_a, m_b;
   logic [1:0]    m_op;
   logic          m_sa, m_sb;

   always @(negedge clk) begin
      logic g0, g1, g;
      logic [DW:0] r;
      if (!rst_n) begin
         m_mode = 0; m_left = 0; m_last = 1'b1; m_id = 1'b0; m_rsign = 1'b0; m_dz = 1'b0;
         m_res = '0; m_a = '0; m_b = '0; m_op = '0; m_sa = 1'b0; m_sb = 1'b0;
      end
      g0 = req0_valid & (!req1_valid | m_last);
      g1 = req1_valid & (!req0_valid | !m_last);
      chk("ready0", req0_ready, (m_mode == 0) & g0);
      chk("ready1", req1_ready, (m_mode == 0) & g1);
      chk("resp_valid", resp_valid, m_mode == 2);
      chk("busy", busy, m_mode != 0);
      chk("resp_id", resp_id, m_id);
      chk("resp_res", resp_res, m_res);
      chk("resp_sign", resp_sign, m_rsign);
      chk("dp_a", dp_num_a, m_a);
      chk("dp_b", dp_num_b, m_b);
      chk("dp_ctl", {dp_op, dp_sign_a, dp_sign_b}, {m_op, m_sa, m_sb});
`ifdef ARITH_SCHED_DZ_FLAG_EN
      chk("resp_dz", resp_dz, m_dz);
`endif
      if (rst_n) begin
         case (m_mode)
            0: if (req0_valid | req1_valid) begin
               g = g1;
               m_op = g ? req1_op : req0_op;
               m_a  = g ? req1_a  : req0_a;
               m_b  = g ? req1_b  : req0_b;
               m_sa = g ? req1_sa : req0_sa;
               m_sb = g ? req1_sb : req0_sb;
               m_last = g;
               m_left = m_op[1] ? MUL_L : ADD_L;
               if (m_op == 2'b11 && m_b == '0) m_left = DZ_L;
               m_mode = 1;
               m_id = m_id; // response id is only updated on capture
            end
            1: begin
               m_left--;
               if (m_left == 0) begin
                  r = unit_f(m_op, m_a, m_b, m_sa, m_sb);
                  m_res = r[DW-1:0]; m_rsign = r[DW]; m_id = m_last;
`ifdef ARITH_SCHED_DZ_FLAG_EN
                  m_dz = (m_op == 2'b11) && (m_b == '0);
`endif
                  m_mode = 2;
               end
            end
            default: if (resp_ready) m_mode = 0;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic set_req(input int r, input logic [1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic sa, input logic sb);
      if (r == 0) begin req0_op = op; req0_a = a; req0_b = b; req0_sa = sa; req0_sb = sb; end
      else        begin req1_op = op; req1_a = a; req1_b = b; req1_sa = sa; req1_sb = sb; end
   endtask

   // Counts edges from the current point until resp_valid is seen (bounded).
   task automatic wait_resp(output int n);
      n = 0;
      while (!resp_valid && n < 40) begin tick(); n++; end
   endtask

   task automatic drain();
      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
      repeat (8) tick();
   endtask

   initial begin
      int n, rcnt;
      int grants[$];
      logic [DW-1:0] allones;
      allones = '1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Add 5+3 on requester 0.
      set_req(0, 2'b00, 5, 3, 0, 0); req0_valid = 1'b1; #1;
      chk("d1_ready0", req0_ready, 1'b1);
      tick(); req0_valid = 1'b0; #1;
      chk("d1_ready0_once", req0_ready, 1'b0);
      wait_resp(n);
      chk("d1_lat", n, ADD_L);
      chk("d1_res", {resp_sign, resp_res}, {1'b0, 128'd8});
      chk("d1_id", resp_id, 1'b0);
      tick(); #1;
      chk("d1_busy", busy, 1'b0);

      // Multiply 6*7 on requester 1.
      set_req(1, 2'b10, 6, 7, 0, 0); req1_valid = 1'b1;
      tick(); req1_valid = 1'b0;
      wait_resp(n);
      chk("d2_lat", n, MUL_L);
      chk("d2_res", resp_res, 128'd42);
      chk("d2_id", resp_id, 1'b1);
      drain();

      // Continuous dual requests: 9-4, grants must alternate.
      set_req(0, 2'b01, 9, 4, 0, 0); set_req(1, 2'b01, 9, 4, 0, 0);
      req0_valid = 1'b1; req1_valid = 1'b1; rcnt = 0; n = 0;
      while (rcnt < 4 && n < 80) begin
         if (grants.size() >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
         #1;
         if (req0_ready) grants.push_back(0);
         if (req1_ready) grants.push_back(1);
         if (resp_valid) begin
            chk("d3_res", resp_res, 128'd5);
            chk("d3_id", resp_id, rcnt[0]);
            rcnt++;
         end
         tick(); n++;
      end
      chk("d3_count", rcnt, 4);
      for (int i = 0; i < grants.size(); i++) chk("d3_order", grants[i], i % 2);
      drain();

      // Back-pressure: response held for 10 cycles while req0 keeps asking.
      resp_ready = 1'b0;
      set_req(0, 2'b00, 1, 2, 0, 0); req0_valid = 1'b1;
      tick();
      wait_resp(n);
      chk("d4_seen", resp_valid, 1'b1);
      repeat (10) begin
         #1;
         chk("d4_hold_v", resp_valid, 1'b1);
         chk("d4_hold_res", resp_res, 128'd3);
         chk("d4_no_grant", req0_ready, 1'b0);
         tick();
      end
      resp_ready = 1'b1;
      tick(); #1;
      chk("d4_regrant", req0_ready, 1'b1);
      tick(); req0_valid = 1'b0;
      drain();

      // Reset in the middle of a divide.
      set_req(0, 2'b11, 100, 7, 0, 0); req0_valid = 1'b1;
      tick(); req0_valid = 1'b0;
      tick();
      rst_n = 1'b0; #1;
      chk("d5_busy", busy, 1'b0);
      chk("d5_valid", resp_valid, 1'b0);
      chk("d5_dp", {dp_op, dp_num_a}, '0);
      chk("d5_res", {resp_id, resp_res}, '0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) begin #1; chk("d5_stale", resp_valid, 1'b0); tick(); end
      set_req(0, 2'b00, 1, 1, 0, 0); set_req(1, 2'b00, 2, 2, 0, 0);
      req0_valid = 1'b1; req1_valid = 1'b1; #1;
      chk("d5_first0", {req0_ready, req1_ready}, 2'b10);
      tick(); req0_valid = 1'b0; req1_valid = 1'b0;
      drain();

      // Divide by zero, negative dividend.
      set_req(1, 2'b11, 10, 0, 1, 0); req1_valid = 1'b1;
      tick(); req1_valid = 1'b0;
      wait_resp(n);
      chk("d6_lat", n, DZ_L);
      chk("d6_res", {resp_sign, resp_res}, {1'b1, allones});
`ifdef ARITH_SCHED_DZ_FLAG_EN
      chk("d6_dz", resp_dz, 1'b1);
`endif
      drain();

      // Randomized traffic; the negedge model checks every cycle.
      for (int i = 0; i < 500; i++) begin
         set_req(0, 2'($urandom), ($urandom_range(0, 3) == 0) ? DW'(0) : {$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 3) == 0) ? DW'(0) : DW'($urandom_range(1, 1000)), 1'($urandom), 1'($urandom));
         set_req(1, 2'($urandom), DW'($urandom), ($urandom_range(0, 4) == 0) ? DW'(0) : DW'($urandom),
                 1'($urandom), 1'($urandom));
         req0_valid = 1'($urandom_range(0, 2) != 0);
         req1_valid = 1'($urandom_range(0, 2) != 0);
         resp_ready = 1'($urandom_range(0, 3) != 0);
         tick();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
